ptp_sync_sched: RTL and testbench
=================================

PTP_SYNC_SCHED -- requirements
Module: ptp_sync_sched

Interface
REQ-001 SHALL have parameter PORT_NUM, default 8: number of requesting MAC ports, 1..8.
REQ-002 SHALL have parameter TMO_WIDTH, default 24: watchdog counter width.
REQ-003 SHALL have parameter TMO_CYCLES, default 2_500_000: watchdog limit in i_clk cycles (10 ms at 250 MHz).
REQ-004 SHALL have port i_clk, input, 1: single 250 MHz clock; the block has one clock.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_req, input, PORT_NUM: per-port PTP frame-pending request, level.
REQ-007 SHALL have port i_link, input, PORT_NUM: per-port link status.
REQ-008 SHALL have port o_ack, output, PORT_NUM: one-cycle grant acknowledge pulse, one-hot.
REQ-009 SHALL have port o_grant, output, PORT_NUM: one-hot held selection driving the PTP ingress mux.
REQ-010 SHALL have port o_grant_idx, output, $clog2(PORT_NUM) (min 1): binary index of o_grant.
REQ-011 SHALL have port o_busy, output, 1: session in progress.
REQ-012 SHALL have ports i_as_valid, i_as_ready, i_as_last, inputs, 1 each: muxed AXI-stream handshake toward the AS engine.
REQ-013 SHALL have port i_channel_end, input, 1: AS engine pulse marking the end of a port's sync round.
REQ-014 SHALL have ports o_abort and o_timeout, outputs, 1 each: one-cycle pulses on link-drop abort and watchdog abort.

Function
REQ-015 SHALL implement states IDLE, XFER, WAIT_END.
REQ-016 In IDLE, SHALL form eligible = i_req & i_link and select the lowest set index (port 0 highest priority).
REQ-017 On a non-zero eligible vector in IDLE at cycle N, SHALL assert o_ack[idx] only in cycle N+1, load o_grant and o_grant_idx, set o_busy, and enter XFER.
REQ-018 o_grant, o_grant_idx and o_busy SHALL remain stable from N+1 until return to IDLE; requests from other ports SHALL be ignored during a session.
REQ-019 In XFER, a cycle with i_as_valid & i_as_ready & i_as_last SHALL move the FSM to WAIT_END.
REQ-020 In WAIT_END, i_channel_end SHALL return the FSM to IDLE and clear o_grant, o_busy and o_grant_idx (to 0) in the next cycle.
REQ-021 i_channel_end in XFER SHALL also end the session and return to IDLE.
REQ-022 If i_link of the granted port is 0 in XFER or WAIT_END, SHALL return to IDLE and pulse o_abort for one cycle; link drop takes precedence over i_channel_end and last in the same cycle.
REQ-023 After any return to IDLE, SHALL spend at least one cycle in IDLE before the next o_ack.
REQ-024 i_as_* and i_channel_end SHALL be ignored in IDLE.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force IDLE, o_ack=0, o_grant=0, o_grant_idx=0, o_busy=0, o_abort=0, o_timeout=0, and a watchdog count of 0, including mid-session.
REQ-026 After release, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-027 Macro PTP_SCHED_WATCHDOG_EN, when defined, SHALL add a TMO_WIDTH counter.
REQ-028 The counter SHALL clear on entry to XFER, increment each cycle in XFER or WAIT_END, and saturate.
REQ-029 When the counter reaches TMO_CYCLES-1 in XFER or WAIT_END, SHALL return to IDLE and pulse o_timeout; link-drop abort takes precedence over timeout.
REQ-030 Without PTP_SCHED_WATCHDOG_EN, SHALL omit the counter, tie o_timeout to 0, and make sessions end only via REQ-019 to REQ-022.

Structure
REQ-031 State encodings and the default TMO_CYCLES SHALL reside in shared package ptp_as_pkg.
REQ-032 SHALL instantiate one sub-module, ptp_prio_enc: a combinational fixed-priority encoder producing a one-hot output and a binary index.
REQ-033 The FSM, watchdog and output registers SHALL be in ptp_sync_sched; all outputs registered.

Verification
REQ-034 i_link=8'hFF, i_req=8'b0010_0100 in one cycle -> o_ack=8'h04 for one cycle next cycle, o_grant_idx=2, o_busy=1.
REQ-035 Granted port 2; last handshake, then i_channel_end 3 cycles later -> o_busy=0 one cycle after end; pending req[5] gives o_ack=8'h20 no earlier than 2 cycles after end.
REQ-036 During a port-2 session, assert i_req[0] -> no o_ack until the session ends; then port 0 wins over port 5.
REQ-037 Granted port 3, i_link[3]=0 in WAIT_END concurrent with i_channel_end -> o_abort=1 for one cycle, o_grant=0 next cycle.
REQ-038 With PTP_SCHED_WATCHDOG_EN and TMO_CYCLES=16, no last or end after grant -> o_timeout pulses 16 cycles after entering XFER; without the macro, o_busy stays 1.
REQ-039 i_rst_n low mid-XFER -> all outputs 0 asynchronously; i_req held -> o_ack reasserts after release.

Source files
------------

// File: rtl/ptp_as_pkg.sv
// Shared types and defaults for the PTP sync scheduler.
package ptp_as_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER     = 2'd1,
    ST_WAIT_END = 2'd2
  } sched_state_t;

  // 10 ms at 250 MHz
  localparam int unsigned TMO_CYCLES_DEF = 2_500_000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptp_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, one-hot and binary index out.
module ptp_prio_enc
  import ptp_as_pkg::*;
#(
  parameter int PORT_NUM = 8
) (
  input  logic [PORT_NUM-1:0]            req,
  output logic [PORT_NUM-1:0]            onehot,
  output logic [idx_width(PORT_NUM)-1:0] idx,
  output logic                           any
);

  localparam int IDX_W = idx_width(PORT_NUM);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (req[i] && !any) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptp_sync_sched.sv
// PTP sync-round scheduler: grants one MAC port at a time to the AS engine.
// Optional session watchdog enabled by defining PTP_SCHED_WATCHDOG_EN.
//
// state       | meaning
// ST_IDLE     | no session; pick lowest eligible port (req & link)
// ST_XFER     | granted port is streaming frames to the AS engine
// ST_WAIT_END | last beat seen, waiting for channel_end from the engine
module ptp_sync_sched
  import ptp_as_pkg::*;
#(
  parameter int PORT_NUM   = 8,
  parameter int TMO_WIDTH  = 24,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [PORT_NUM-1:0]             i_req,
  input  logic [PORT_NUM-1:0]             i_link,
  output logic [PORT_NUM-1:0]             o_ack,
  output logic [PORT_NUM-1:0]             o_grant,
  output logic [idx_width(PORT_NUM)-1:0]  o_grant_idx,
  output logic                            o_busy,
  input  logic                            i_as_valid,
  input  logic                            i_as_ready,
  input  logic                            i_as_last,
  input  logic                            i_channel_end,
  output logic                            o_abort,
  output logic                            o_timeout
);

  localparam int IDX_W = idx_width(PORT_NUM);

  sched_state_t        state;
  logic                armed;
  logic [PORT_NUM-1:0] eligible;
  logic [PORT_NUM-1:0] sel_onehot;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_any;
  logic                link_ok;
  logic                hs_last;
  logic                wd_hit;
  logic                sess_end;
  logic                end_abort;
  logic                end_tmo;

  assign eligible = i_req & i_link;

  ptp_prio_enc #(.PORT_NUM(PORT_NUM)) u_prio_enc (
    .req    (eligible),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign link_ok = |(i_link & o_grant);
  assign hs_last = i_as_valid & i_as_ready & i_as_last;

`ifdef PTP_SCHED_WATCHDOG_EN
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);

  logic [TMO_WIDTH-1:0] wdog_cnt;

  // Cleared on the grant edge so the first session cycle reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (armed && sel_any) wdog_cnt <= '0;
    end else if (wdog_cnt != '1) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wd_hit = (wdog_cnt >= TMO_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  // Link drop beats channel_end, which beats the watchdog.
  always_comb begin
    end_abort = !link_ok;
    end_tmo   = link_ok && !i_channel_end && wd_hit;
    sess_end  = !link_ok || i_channel_end || wd_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      o_ack       <= '0;
      o_grant     <= '0;
      o_grant_idx <= '0;
      o_busy      <= 1'b0;
      o_abort     <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      armed     <= 1'b1;
      o_ack     <= '0;
      o_abort   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && sel_any) begin
            state       <= ST_XFER;
            o_ack       <= sel_onehot;
            o_grant     <= sel_onehot;
            o_grant_idx <= sel_idx;
            o_busy      <= 1'b1;
          end
        end
        ST_XFER, ST_WAIT_END: begin
          if (sess_end) begin
            state       <= ST_IDLE;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_busy      <= 1'b0;
            o_abort     <= end_abort;
            o_timeout   <= end_tmo;
          end else if (state == ST_XFER && hs_last) begin
            state <= ST_WAIT_END;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptp_sync_sched.sv
// Randomized + directed bench for ptp_sync_sched against a session-level model.
module tb_ptp_sync_sched;

  localparam int N   = 8;
  localparam int TMO = 16;
`ifdef PTP_SCHED_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, link;
  logic       as_valid, as_ready, as_last, chan_end;
  logic [7:0] ack, grant;
  logic [2:0] grant_idx;
  logic       busy, abort_p, tmo_p;

  always #5 clk = ~clk;

  ptp_sync_sched #(.PORT_NUM(N), .TMO_WIDTH(24), .TMO_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_link        (link),
    .o_ack         (ack),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_busy        (busy),
    .i_as_valid    (as_valid),
    .i_as_ready    (as_ready),
    .i_as_last     (as_last),
    .i_channel_end (chan_end),
    .o_abort       (abort_p),
    .o_timeout     (tmo_p)
  );

  int total = 0;
  int bad   = 0;

  // Session-level model: who holds the grant and for how long.
  bit         m_busy, m_armed, m_abort, m_to;
  int         m_port, m_age;
  logic [7:0] m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_armed = 0; m_abort = 0; m_to = 0;
    m_port = 0; m_age = 0; m_ack = '0;
  endtask

  task automatic model_step();
    m_ack = '0; m_abort = 0; m_to = 0;
    if (!m_busy) begin
      if (m_armed) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && link[i]) begin
            m_busy = 1; m_port = i; m_age = 0; m_ack[i] = 1'b1;
            break;
          end
        end
      end
    end else begin
      m_age++;
      if (!link[m_port])              begin m_busy = 0; m_abort = 1; end
      else if (chan_end)              m_busy = 0;
      else if (WD_EN && m_age >= TMO) begin m_busy = 0; m_to = 1; end
    end
    m_armed = 1;
  endtask

  task automatic check_all();
    logic [7:0] g;
    g = m_busy ? (8'h01 << m_port) : 8'h00;
    chk("ack",     ack,       m_ack);
    chk("grant",   grant,     g);
    chk("idx",     grant_idx, m_busy ? m_port : 0);
    chk("busy",    busy,      m_busy);
    chk("abort",   abort_p,   m_abort);
    chk("timeout", tmo_p,     m_to);
  endtask

  task automatic step(input logic [7:0] rq, input logic [7:0] lk,
                      input logic v, input logic r, input logic l, input logic e);
    req = rq; link = lk; as_valid = v; as_ready = r; as_last = l; chan_end = e;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  int         end_div, drop_div;
  logic [7:0] drop;

  initial begin
    rst_n = 1'b0;
    req = '0; link = '0; as_valid = 0; as_ready = 0; as_last = 0; chan_end = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    rst_n = 1'b1;

    // First edge after release only arms; grant on the second.
    step(8'h01, 8'hFF, 0, 0, 0, 0);
    chk("arm_no_ack", ack, 8'h00);
    step(8'h01, 8'hFF, 0, 0, 0, 0);
    chk("first_ack", ack, 8'h01);
    step(8'h00, 8'hFF, 0, 0, 0, 1);
    step(8'h00, 8'hFF, 0, 0, 0, 0);

    // Two requesters, lowest wins.
    step(8'h24, 8'hFF, 0, 0, 0, 0);
    chk("p2_ack", ack, 8'h04);
    chk("p2_idx", grant_idx, 2);
    chk("p2_busy", busy, 1);
    step(8'h20, 8'hFF, 1, 1, 1, 0);
    chk("ack_one_cycle", ack, 8'h00);
    step(8'h20, 8'hFF, 0, 0, 0, 0);
    step(8'h20, 8'hFF, 0, 0, 0, 0);
    step(8'h20, 8'hFF, 0, 0, 0, 1);
    chk("end_busy", busy, 0);
    chk("end_no_ack", ack, 8'h00);
    step(8'h20, 8'hFF, 0, 0, 0, 0);
    chk("p5_ack", ack, 8'h20);

    // Higher-priority request ignored mid-session, wins afterwards.
    step(8'h00, 8'hFF, 0, 0, 0, 1);
    step(8'h04, 8'hFF, 0, 0, 0, 0);
    chk("p2b_ack", ack, 8'h04);
    for (int i = 0; i < 4; i++) begin
      step(8'h25, 8'hFF, 0, 0, 0, 0);
      chk("sess_no_ack", ack, 8'h00);
    end
    step(8'h25, 8'hFF, 0, 0, 0, 1);
    chk("sess_end_busy", busy, 0);
    step(8'h21, 8'hFF, 0, 0, 0, 0);
    chk("p0_ack", ack, 8'h01);
    chk("p0_idx", grant_idx, 0);

    // Link drop with concurrent channel_end -> abort.
    step(8'h00, 8'hFF, 0, 0, 0, 1);
    step(8'h08, 8'hFF, 0, 0, 0, 0);
    chk("p3_ack", ack, 8'h08);
    step(8'h00, 8'hFF, 1, 1, 1, 0);
    step(8'h00, 8'hF7, 0, 0, 0, 1);
    chk("abort_pulse", abort_p, 1);
    chk("abort_grant", grant, 8'h00);
    step(8'h00, 8'hFF, 0, 0, 0, 0);
    chk("abort_once", abort_p, 0);

    // Stalled session: watchdog or indefinite hold.
    step(8'h02, 8'hFF, 0, 0, 0, 0);
    chk("p1_ack", ack, 8'h02);
    for (int k = 1; k <= TMO; k++) begin
      step(8'h00, 8'hFF, 0, 0, 0, 0);
      if (k == TMO - 1) begin
        chk("pre_tmo", tmo_p, 0);
        chk("pre_tmo_busy", busy, 1);
      end
    end
`ifdef PTP_SCHED_WATCHDOG_EN
    chk("tmo_pulse", tmo_p, 1);
    chk("tmo_busy", busy, 0);
`else
    chk("no_wd_busy", busy, 1);
    chk("no_wd_tmo", tmo_p, 0);
`endif
    step(8'h00, 8'hFF, 0, 0, 0, 1);

    // Asynchronous reset mid-session.
    step(8'h10, 8'hFF, 0, 0, 0, 0);
    chk("p4_ack", ack, 8'h10);
    step(8'h10, 8'hFF, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_grant", grant, 0);
    chk("arst_idx", grant_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_abort", abort_p, 0);
    chk("arst_tmo", tmo_p, 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(8'h10, 8'hFF, 0, 0, 0, 0);
    chk("rearm_no_ack", ack, 8'h00);
    step(8'h10, 8'hFF, 0, 0, 0, 0);
    chk("reack", ack, 8'h10);

    // Randomized traffic in phases of varying end/link-drop rates.
    end_div = 4; drop_div = 64;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        end_div  = ($urandom_range(0, 1) == 0) ? 4 : 40;
        drop_div = ($urandom_range(0, 1) == 0) ? 16 : 400;
      end
      drop = '0;
      for (int b = 0; b < N; b++)
        drop[b] = ($urandom_range(0, drop_div - 1) == 0);
      step(8'($urandom), ~drop, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, end_div - 1) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
